// File: rtl/id_ex_pipe_stage.sv
// Purpose: ID/EX pipeline register with valid/ready handshake, flush-to-bubble and stall counter.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle sustained with out_ready high.
// Backpressure: holds the beat while out_ready is low; in_ready drops once storage is full.
//
// Optional feature macro: ID_EX_SKID_EN
//   defined   -> adds a skid entry (2 beats buffered); in_ready is a register (!skid_valid)
//   undefined -> single entry; in_ready = !out_valid || out_ready, forced low in reset
//
// Ports:
//   clk, rst             : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready  : decode-side handshake
//   ctrl_in ... rd_in    : decoded control bundle, operands, immediate, register specifiers
//   out_valid / out_ready: execute-side handshake
//   ctrl_out ... rd_out  : registered fields; ctrl_out is all-zero whenever out_valid is low
//   flush                : drop the held beat(s) and any beat offered this cycle
//   clr_cnt, stall_cnt   : clear / saturating count of cycles with out_valid && !out_ready

module id_ex_pipe_stage #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 32,
    parameter int IMM_W  = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [RA_W-1:0]   rs_in,
    input  logic [RA_W-1:0]   rt_in,
    input  logic [RA_W-1:0]   rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [RA_W-1:0]   rs_out,
    output logic [RA_W-1:0]   rt_out,
    output logic [RA_W-1:0]   rd_out,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BEAT_W = CTRL_W + 2 * DATA_W + IMM_W + 3 * RA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              accept;
    logic              consume;
    logic [BEAT_W-1:0] in_bus;

    assign in_bus  = {ctrl_in, rd1_in, rd2_in, imm_in, rs_in, rt_in, rd_in};
    assign accept  = in_valid && in_ready && !flush;
    assign consume = out_valid && out_ready;

`ifdef ID_EX_SKID_EN
    logic              skid_valid;
    logic              skid_valid_nxt;
    logic [BEAT_W-1:0] skid_dat;
    logic              in_ready_q;

    assign in_ready = in_ready_q;

    // in_ready is low whenever the skid entry is full, so accept and a full
    // skid never coincide; a consume therefore always leaves the skid empty.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (flush) begin
            skid_valid_nxt = 1'b0;
        end else if (consume) begin
            skid_valid_nxt = 1'b0;
        end else if (accept && out_valid) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= '0;
            skid_valid <= 1'b0;
            skid_dat   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready_q <= !skid_valid_nxt;
            if (flush) begin
                out_valid <= 1'b0;
                ctrl_out  <= '0;
            end else if (consume) begin
                if (skid_valid) begin
                    // Older buffered beat advances; order is preserved.
                    {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= skid_dat;
                end else if (accept) begin
                    {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= in_bus;
                end else begin
                    out_valid <= 1'b0;
                    ctrl_out  <= '0;
                end
            end else if (accept) begin
                if (out_valid) begin
                    skid_dat <= in_bus;
                end else begin
                    out_valid <= 1'b1;
                    {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= in_bus;
                end
            end
        end
    end
`else
    // Ready passes straight through from execute so a full entry can be
    // replaced in the same cycle it is consumed.
    assign in_ready = rst && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_out  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            {ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out} <= in_bus;
        end else if (consume) begin
            // Bubble: control goes to zero, datapath fields keep their last value.
            out_valid <= 1'b0;
            ctrl_out  <= '0;
        end
    end
`endif

    // Stall counter: clear beats increment in the same cycle; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: directed steps followed by random traffic, all
// checked against a queue-based reference model of the stage's storage.
// Built with a 4-bit stall counter so saturation is reachable quickly.

module tb_id_ex_pipe_stage;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } beat_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    beat_t            in_b;
    logic             out_valid;
    logic             out_ready;
    logic [8:0]       ctrl_out;
    logic [31:0]      rd1_out;
    logic [31:0]      rd2_out;
    logic [31:0]      imm_out;
    logic [4:0]       rs_out;
    logic [4:0]       rt_out;
    logic [4:0]       rd_out;
    logic             flush;
    logic             clr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    beat_t q[$];
    beat_t last;
    int    cnt;
    bit    ir_reg;

    id_ex_pipe_stage #(
        .CTRL_W(9), .DATA_W(32), .IMM_W(32), .RA_W(5), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl_in   (in_b.ctrl),
        .rd1_in    (in_b.rd1),
        .rd2_in    (in_b.rd2),
        .imm_in    (in_b.imm),
        .rs_in     (in_b.rs),
        .rt_in     (in_b.rt),
        .rd_in     (in_b.rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_out  (ctrl_out),
        .rd1_out   (rd1_out),
        .rd2_out   (rd2_out),
        .imm_out   (imm_out),
        .rs_out    (rs_out),
        .rt_out    (rt_out),
        .rd_out    (rd_out),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_in_ready();
`ifdef ID_EX_SKID_EN
        return ir_reg;
`else
        return rst && (q.size() == 0 || out_ready);
`endif
    endfunction

    function automatic int capacity();
`ifdef ID_EX_SKID_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs applied to the DUT.
    task automatic model_edge();
        bit acc;
        bit stall;
        if (!rst) begin
            q.delete();
            last   = '0;
            cnt    = 0;
            ir_reg = 1'b0;
        end else begin
            acc   = in_valid && model_in_ready() && !flush;
            stall = (q.size() > 0) && !out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(in_b);
            end
            if (clr_cnt) cnt = 0;
            else if (stall && cnt < MAXC) cnt++;
            ir_reg = (q.size() < capacity());
            if (q.size() > 0) last = q[0];
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (q.size() > 0);
        check("out_valid", 64'(out_valid), 64'(v));
        check("ctrl_out",  64'(ctrl_out),  v ? 64'(q[0].ctrl) : 64'd0);
        check("rd1_out",   64'(rd1_out),   64'(last.rd1));
        check("rd2_out",   64'(rd2_out),   64'(last.rd2));
        check("imm_out",   64'(imm_out),   64'(last.imm));
        check("rs_out",    64'(rs_out),    64'(last.rs));
        check("rt_out",    64'(rt_out),    64'(last.rt));
        check("rd_out",    64'(rd_out),    64'(last.rd));
        check("stall_cnt", 64'(stall_cnt), 64'(cnt));
    endtask

    // One cycle: check in_ready for the applied inputs, clock, then check outputs.
    task automatic step();
        #1;
        check("in_ready", 64'(in_ready), 64'(model_in_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic beat_t rand_beat(input logic [31:0] imm);
        beat_t b;
        b.ctrl = 9'($urandom_range(1, 511));
        b.rd1  = $urandom;
        b.rd2  = $urandom;
        b.imm  = imm;
        b.rs   = 5'($urandom);
        b.rt   = 5'($urandom);
        b.rd   = 5'($urandom);
        return b;
    endfunction

    logic [31:0] imms [4];

    initial begin
        imms[0] = 32'hFFFF_8000;
        imms[1] = 32'h0000_0001;
        imms[2] = 32'h0000_0002;
        imms[3] = 32'h0000_0003;

        // Reset held for two edges with a beat offered
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_b      = rand_beat(32'h1234_5678);
        in_b.ctrl = 9'h1FF;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_ctrl_out", 64'(ctrl_out), 64'd0);

        // Release reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("rel_in_ready", 64'(in_ready), 64'd1);

        // Streaming, one beat per cycle
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_b     = rand_beat(imms[k]);
            step();
            check("stream_vld", 64'(out_valid), 64'd1);
            check("stream_imm", 64'(imm_out), 64'(imms[k]));
        end
        in_valid = 1'b0;
        step();
        step();

        // Back-pressure: beat A held for 5 stall cycles while B is offered
        clr_cnt   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_b      = rand_beat(32'h0000_000A);
        step();
        clr_cnt = 1'b0;
        in_b    = rand_beat(32'h0000_000B);
        repeat (5) step();
        check("bp_stall_cnt", 64'(stall_cnt), 64'd5);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_imm", 64'(imm_out), 64'h0A);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
`ifdef ID_EX_SKID_EN
        check("skid_second_vld", 64'(out_valid), 64'd1);
        check("skid_second_imm", 64'(imm_out), 64'h0B);
        step();
`endif
        check("bp_drained", 64'(out_valid), 64'd0);

        // Counter saturation then clear during a stall
        clr_cnt   = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_b      = rand_beat(32'h0000_000C);
        step();
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        repeat (20) step();
        check("cnt_saturate", 64'(stall_cnt), 64'd15);
        clr_cnt = 1'b1;
        step();
        check("cnt_clear_wins", 64'(stall_cnt), 64'd0);
        clr_cnt = 1'b0;

        // Flush with a held beat and a new beat offered
        in_valid = 1'b1;
        in_b     = rand_beat(32'h0000_000D);
        flush    = 1'b1;
        step();
        check("flush_vld", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(ctrl_out), 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flush_dropped", 64'(out_valid), 64'd0);
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 59) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_b      = rand_beat($urandom);
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 11) == 0;
            clr_cnt   = $urandom_range(0, 15) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage carrying decoded control, register operands, a full-width immediate and register specifiers from decode to execute. It adds a valid/ready handshake, back-pressure stall, synchronous flush (bubble insertion) and a saturating stall counter. An optional skid entry registers the upstream ready path. It sits between the decode stage and the ALU/forwarding logic and replaces the fixed-width ID/EX register.

## Interface
Parameters:
- CTRL_W, 9, packed control width: {mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src, ALU_op[2:0]}
- DATA_W, 32, register operand width
- IMM_W, 32, sign-extended immediate width (full word, not truncated)
- RA_W, 5, register specifier width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous and active-low
- in_valid  in  1  decode presents a beat
- in_ready  out  1  stage can accept a beat
- ctrl_in  in  CTRL_W  control bundle
- rd1_in, rd2_in  in  DATA_W  register file read data
- imm_in  in  IMM_W  sign-extended immediate
- rs_in, rt_in, rd_in  in  RA_W  register specifiers
- out_valid  out  1  execute beat valid
- out_ready  in  1  execute can consume
- ctrl_out, rd1_out, rd2_out, imm_out, rs_out, rt_out, rd_out  out  same widths as inputs  registered fields
- flush  in  1  kill held and incoming beats (branch/jump redirect)
- clr_cnt  in  1  clear stall counter
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Accept: in_valid && in_ready && !flush. Consume: out_valid && out_ready.
- Base mode: single entry; in_ready = !out_valid || out_ready, forced 0 while rst is low.
- On accept, all fields load and out_valid <= 1. On consume without accept, out_valid <= 0. Simultaneous consume and accept: new beat replaces old, out_valid stays 1.
- No accept and no consume: all fields hold (stall).
- Bubble rule: ctrl_out is all-zero whenever out_valid is 0. Datapath fields (rd1/rd2/imm/rs/rt/rd) retain their last value when invalid.
- flush has priority over everything. Next cycle: out_valid = 0, ctrl_out = 0, skid entry emptied. Any beat offered in the flush cycle is dropped; in_ready still follows its normal rule.
- stall_cnt: +1 on each cycle with out_valid && !out_ready. Saturates at 2^CNT_W-1. clr_cnt zeroes it; clr_cnt wins over an increment in the same cycle.
- Reset (rst low at a clk edge): out_valid, every *_out field, stall_cnt and skid state all become 0. The beat in flight is discarded.

## Timing
- Latency 1 cycle from accept to out_valid.
- Throughput 1 beat/cycle with out_ready held high.
- Base mode: in_ready is combinational from out_ready.
- Skid mode: in_ready is a register and equals !skid_valid.
- flush and clr_cnt take effect at the next rising edge.
- rst deasserted: in_ready is 1 in the first cycle after the release edge.

## Configuration
- ID_EX_SKID_EN defined: a second (skid) entry is added, and in_ready becomes registered (!skid_valid).
  - A beat accepted while the main entry is valid and not consumed goes to skid.
  - On consume, skid moves to main.
  - Order is preserved.
  - Up to 2 beats are buffered.
- ID_EX_SKID_EN undefined: single entry with combinational in_ready as above; no skid storage is synthesised.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 and ctrl_in=9'h1FF. Required: out_valid=0, ctrl_out=0, stall_cnt=0 and in_ready=0 during reset; in_ready=1 after release.
- Streaming: out_ready=1, send 4 beats with imm_in=32'hFFFF_8000, 1, 2, 3. Required: out_valid high from cycle+1; imm_out is the full 32 bits, in order, one per cycle.
- Back-pressure: out_ready=0 for 5 cycles with a beat held. Required: fields stable and stall_cnt=5.
  - Base mode: in_ready=0.
  - Skid mode: one extra beat is accepted, then in_ready=0; after release, both beats emerge in order.
- Flush: flush=1 with a valid held beat and in_valid=1. Required: next cycle out_valid=0, ctrl_out=0, and neither beat ever appears.
- Counter: with CNT_W=4, stall 20 cycles. Required: stall_cnt saturates at 15. Then clr_cnt=1 together with a stall cycle. Required: stall_cnt=0.
